exp_job_sequencer: RTL

- Upstream feeder for the exp accelerator.
- Buffers incoming x operands in a small FIFO and drives the accelerator's start/x interface one job at a time.
- Waits for the accelerator's done handshake, captures the result, and presents it downstream on a valid/ready port.
- Includes a watchdog that detects a hung accelerator.

---
 rtl/exp_job_sequencer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/exp_job_sequencer.sv
// Feeds x operands from a small FIFO to the exp accelerator one job at a time and returns results on a valid/ready port.
// Latency: 1 cycle from a visible FIFO entry to acc_start, 1 cycle from acc_done to res_valid; stalls in S_OUT until res_ready.

// Plain circular FIFO with an occupancy counter; push is ignored when full, pop when empty.
// Zero-latency head; no push-through bypass when full.
module exp_job_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end
endmodule

module exp_job_sequencer #(
    parameter int X_W   = 16,
    parameter int R_W   = 16,
    parameter int DEPTH = 4,
    parameter int TMO   = 255
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    input  logic [X_W-1:0] in_data,
    output logic           in_ready,
    output logic           acc_start,
    output logic [X_W-1:0] acc_x,
    input  logic           acc_done,
    input  logic [R_W-1:0] acc_result,
    output logic           res_valid,
    output logic [R_W-1:0] res_data,
    input  logic           res_ready,
    output logic           busy,
    output logic           err,
    output logic [15:0]    job_cnt
);
    localparam int WD_W = $clog2(TMO + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ARM,
        S_RUN,
        S_OUT
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [WD_W-1:0] wd_cnt;
    logic            fifo_full;
    logic            fifo_empty;
    logic [X_W-1:0]  fifo_head;
    logic            push;
    logic            launch;
    logic            finish;
    logic            wd_hit;
    logic            timeout;

    assign in_ready = !fifo_full;
    assign push     = in_valid && !fifo_full;
    assign launch   = (state == S_IDLE) && !fifo_empty && acc_done;
    assign finish   = (state == S_RUN) && acc_done;
    assign wd_hit   = (wd_cnt == WD_W'(TMO - 1));
    // A done sample in S_RUN wins over a timeout landing on the same cycle.
    assign timeout  = wd_hit && ((state == S_ARM) || ((state == S_RUN) && !acc_done));

    exp_job_fifo #(
        .W     (X_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (in_data),
        .pop       (launch),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (launch) state_nxt = S_START;
            S_START: state_nxt = S_ARM;
            S_ARM: begin
                if (timeout)       state_nxt = S_IDLE;
                else if (!acc_done) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (finish)       state_nxt = S_OUT;
                else if (timeout) state_nxt = S_IDLE;
            end
            S_OUT:   if (res_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        acc_start = (state == S_START);
        res_valid = (state == S_OUT);
        busy      = (state != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_x    <= '0;
            res_data <= '0;
            err      <= 1'b0;
            job_cnt  <= '0;
            wd_cnt   <= '0;
        end else begin
            if (launch) acc_x <= fifo_head;
            if (state == S_START)
                wd_cnt <= '0;
            else if ((state == S_ARM) || (state == S_RUN))
                wd_cnt <= wd_cnt + 1'b1;
            if (timeout) err <= 1'b1;
            if (finish) begin
                res_data <= acc_result;
                job_cnt  <= job_cnt + 16'd1;
            end
        end
    end
endmodule
